// File: rtl/decoder_pkg.sv
// Shared definitions for the scan decoder family: mode encodings and the
// one-hot helper used by both the decoder datapath and its callers.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest one-hot vector the helper can build; decoders with SEL_W <= 6 fit.
  localparam int ONEHOT_W = 64;

  // One-hot of sel within a field of 'width' bits; out-of-range sel gives zero.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned sel,
                                                 input int unsigned width);
    logic [ONEHOT_W-1:0] result;
    if (sel < width) begin
      result = 64'd1 << sel;
    end else begin
      result = 64'd0;
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Circular next-channel search: finds the first index after idx, wrapping
// around, whose mask bit is set. The mask is rotated so that position 0 is the
// channel just after idx, then a lowest-set-bit priority encoder picks it.
module scan_next_sel
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  localparam int NOUT = 2**SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  input  logic [NOUT-1:0]  mask,
  output logic [SEL_W-1:0] nxt,
  output logic             vld
);

  logic [NOUT-1:0]  rot_s;
  logic [SEL_W-1:0] off_s;

  // Rotate the mask so bit i corresponds to channel idx+1+i (mod NOUT).
  always_comb begin
    rot_s = {NOUT{1'b0}};
    for (int i = 0; i < NOUT; i++) begin
      rot_s[i] = mask[idx + SEL_W'(i + 1)];
    end
  end

  // Priority-encode the lowest set bit of the rotated mask.
  always_comb begin
    off_s = {SEL_W{1'b0}};
    for (int i = NOUT - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SEL_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Undo the rotation; an all-zero mask has no successor.
  always_comb begin
    nxt = idx + SEL_W'(1) + off_s;
    vld = |mask;
  end

endmodule

// File: rtl/scan_decoder_nbit.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable and a scan mode that
// walks the active channel at a rate of one step every PRESCALE cycles.
// Optional feature: define SCAN_MASK_EN to add the Mask port; scan then skips
// masked channels and blanks a masked current channel. Direct mode never uses
// Mask. Without the macro every channel is visited in order.
module scan_decoder_nbit
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 4,
  localparam int NOUT    = 2**SEL_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Mode,
  input  logic             Load,
  input  logic [SEL_W-1:0] W,
`ifdef SCAN_MASK_EN
  input  logic [NOUT-1:0]  Mask,
`endif
  output logic [NOUT-1:0]  Y,
  output logic [SEL_W-1:0] Idx,
  output logic             Tick
);

  // Dwell counter only has to reach PRESCALE-1; keep at least one bit.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [NOUT-1:0]  y_r;
  logic [SEL_W-1:0] idx_r;
  logic             tick_r;
  logic [CW-1:0]    cnt_r;

  logic [SEL_W-1:0] nxt_s;
  logic             nxt_vld_s;
  logic [NOUT-1:0]  mask_s;
  logic [NOUT-1:0]  oh_w_s;
  logic [NOUT-1:0]  oh_idx_s;
  logic [NOUT-1:0]  oh_nxt_s;

`ifdef SCAN_MASK_EN
  scan_next_sel #(
    .SEL_W (SEL_W)
  ) u_next (
    .idx  (idx_r),
    .mask (Mask),
    .nxt  (nxt_s),
    .vld  (nxt_vld_s)
  );

  // Scan outputs are gated by the channel mask.
  always_comb begin
    mask_s = Mask;
  end
`else
  // Unmasked scan: plain wrapping increment, every channel visible.
  always_comb begin
    nxt_s     = idx_r + SEL_W'(1);
    nxt_vld_s = 1'b1;
    mask_s    = {NOUT{1'b1}};
  end
`endif

  // One-hot images of the load value, the current index and the successor.
  always_comb begin
    oh_w_s   = NOUT'(onehot(32'(W), 32'(NOUT)));
    oh_idx_s = NOUT'(onehot(32'(idx_r), 32'(NOUT)));
    oh_nxt_s = NOUT'(onehot(32'(nxt_s), 32'(NOUT)));
  end

  // Decoder state: reset, blanking, direct decode and prescaled scan stepping.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      y_r    <= {NOUT{1'b0}};
      idx_r  <= {SEL_W{1'b0}};
      tick_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (!En) begin
      // Blank outputs but freeze index and dwell so scanning resumes mid-dwell.
      y_r    <= {NOUT{1'b0}};
      tick_r <= 1'b0;
    end else if (Mode == MODE_DIRECT) begin
      y_r    <= oh_w_s;
      idx_r  <= W;
      tick_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (Load) begin
      // Load beats a step that falls due in the same cycle.
      y_r    <= oh_w_s & mask_s;
      idx_r  <= W;
      tick_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CW{1'b0}};
      if (nxt_vld_s) begin
        y_r    <= oh_nxt_s & mask_s;
        idx_r  <= nxt_s;
        tick_r <= 1'b1;
      end else begin
        // Nothing selectable: stay put and stay dark.
        y_r    <= {NOUT{1'b0}};
        tick_r <= 1'b0;
      end
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      y_r    <= oh_idx_s & mask_s;
      tick_r <= 1'b0;
    end
  end

  assign Y    = y_r;
  assign Idx  = idx_r;
  assign Tick = tick_r;

endmodule
